// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter: one transaction at a time among 2**N requesters.
// Define ARB_ROUND_ROBIN_EN for rotating priority; otherwise highest index wins.
module mem_port_arbiter #(
    parameter int N  = 2,
    parameter int AW = 32,
    parameter int DW = 32
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic [2**N-1:0]      req,
    input  logic [2**N-1:0]      req_we,
    input  logic [(2**N)*AW-1:0] req_addr,
    input  logic [(2**N)*DW-1:0] req_wdata,
    output logic [2**N-1:0]      done,
    output logic [DW-1:0]        rdata,
    output logic [N-1:0]         owner,
    output logic                 busy,
    output logic                 mem_valid,
    input  logic                 mem_ready,
    output logic                 mem_we,
    output logic [AW-1:0]        mem_addr,
    output logic [DW-1:0]        mem_wdata,
    input  logic [DW-1:0]        mem_rdata
);
    localparam int NR = 2**N;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    state_t state_reg, state_next;

    logic [AW-1:0] addr_arr  [NR];
    logic [DW-1:0] wdata_arr [NR];
    logic [NR-1:0] owner_onehot;
    logic [N-1:0]  owner_reg;
    logic          mem_we_reg;
    logic [AW-1:0] mem_addr_reg;
    logic [DW-1:0] mem_wdata_reg;
    logic [DW-1:0] rdata_reg;
    logic [N-1:0]  win;
    logic          win_valid;
    logic          grant;

    generate
        for (genvar gi = 0; gi < NR; gi++) begin : g_req
            assign addr_arr[gi]     = req_addr[gi*AW +: AW];
            assign wdata_arr[gi]    = req_wdata[gi*DW +: DW];
            assign owner_onehot[gi] = (owner_reg == N'(gi));
        end
    endgenerate

`ifdef ARB_ROUND_ROBIN_EN
    logic [N-1:0] last_reg;
    logic [N-1:0] cand;

    // Scan from farthest to nearest so the requester right after last_reg wins.
    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        cand      = '0;
        for (int off = NR; off >= 1; off--) begin
            cand = last_reg + N'(off);
            if (req[cand]) begin
                win       = cand;
                win_valid = 1'b1;
            end
        end
    end
`else
    // Ascending scan: the highest set index is assigned last and wins.
    always_comb begin
        win       = '0;
        win_valid = 1'b0;
        for (int i = 0; i < NR; i++) begin
            if (req[i]) begin
                win       = N'(i);
                win_valid = 1'b1;
            end
        end
    end
`endif

    assign grant = (state_reg == IDLE) && win_valid;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state_reg <= IDLE;
        else       state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (win_valid) state_next = BUSY;
            BUSY:    if (mem_ready) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Outputs decode only registered state, never req or mem_ready.
    always_comb begin
        mem_valid = 1'b0;
        busy      = 1'b0;
        done      = '0;
        case (state_reg)
            BUSY: begin
                mem_valid = 1'b1;
                busy      = 1'b1;
            end
            DONE: begin
                busy = 1'b1;
                done = owner_onehot;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            owner_reg     <= '0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            rdata_reg     <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_reg      <= '1;
`endif
        end else begin
            if (grant) begin
                owner_reg     <= win;
                mem_we_reg    <= req_we[win];
                mem_addr_reg  <= addr_arr[win];
                mem_wdata_reg <= wdata_arr[win];
`ifdef ARB_ROUND_ROBIN_EN
                last_reg      <= win;
`endif
            end
            if (state_reg == BUSY && mem_ready) begin
                rdata_reg <= mem_rdata;
            end
        end
    end

    assign owner     = owner_reg;
    assign mem_we    = mem_we_reg;
    assign mem_addr  = mem_addr_reg;
    assign mem_wdata = mem_wdata_reg;
    assign rdata     = rdata_reg;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed plus randomized bench for mem_port_arbiter with a transaction-level model.
// Honors ARB_ROUND_ROBIN_EN the same way the design does.
module tb_mem_port_arbiter;
    localparam int N  = 2;
    localparam int NR = 2**N;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rstn;
    logic [NR-1:0]     req;
    logic [NR-1:0]     req_we;
    logic [NR*AW-1:0]  req_addr;
    logic [NR*DW-1:0]  req_wdata;
    logic [NR-1:0]     done;
    logic [DW-1:0]     rdata;
    logic [N-1:0]      owner;
    logic              busy;
    logic              mem_valid;
    logic              mem_ready;
    logic              mem_we;
    logic [AW-1:0]     mem_addr;
    logic [DW-1:0]     mem_wdata;
    logic [DW-1:0]     mem_rdata;

    mem_port_arbiter #(.N(N), .AW(AW), .DW(DW)) dut (
        .clk(clk), .rstn(rstn), .req(req), .req_we(req_we), .req_addr(req_addr),
        .req_wdata(req_wdata), .done(done), .rdata(rdata), .owner(owner), .busy(busy),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic [NR-1:0] pend;
    logic [AW-1:0] addr_a [NR];
    logic [DW-1:0] wd_a   [NR];
    logic          we_a   [NR];
`ifdef ARB_ROUND_ROBIN_EN
    int last_m;
`endif

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Winner from the selection rule, using modulo arithmetic on the pointer.
    function automatic int pick(input logic [NR-1:0] r);
        int idx;
`ifdef ARB_ROUND_ROBIN_EN
        for (int off = 1; off <= NR; off++) begin
            idx = (last_m + off) % NR;
            if (r[idx]) return idx;
        end
`else
        for (idx = NR - 1; idx >= 0; idx--) begin
            if (r[idx]) return idx;
        end
`endif
        return -1;
    endfunction

    task automatic drive_cmds();
        for (int i = 0; i < NR; i++) begin
            req_addr[i*AW +: AW]  = addr_a[i];
            req_wdata[i*DW +: DW] = wd_a[i];
            req_we[i]             = we_a[i];
        end
    endtask

    task automatic raise(input logic [NR-1:0] bits);
        for (int i = 0; i < NR; i++) begin
            if (bits[i] && !pend[i]) begin
                addr_a[i] = $urandom;
                wd_a[i]   = $urandom;
                we_a[i]   = 1'($urandom_range(0, 1));
            end
        end
        pend = pend | bits;
    endtask

    task automatic run_txn(input int stall, input bit drop, input int want, input logic [DW-1:0] rd);
        int w;
        logic [AW-1:0] e_addr;
        logic [DW-1:0] e_wd;
        logic          e_we;
        drive_cmds();
        req       = pend;
        mem_ready = 1'b0;
        w = pick(pend);
        @(negedge clk);
        chk("grant_valid", 64'(mem_valid), 64'd1);
        chk("grant_owner", 64'(owner), 64'(w));
        if (want >= 0) chk("grant_directed", 64'(owner), 64'(want));
        chk("grant_addr", 64'(mem_addr), 64'(addr_a[w]));
        chk("grant_we", 64'(mem_we), 64'(we_a[w]));
        chk("grant_wdata", 64'(mem_wdata), 64'(wd_a[w]));
        chk("grant_busy", 64'(busy), 64'd1);
        chk("grant_nodone", 64'(done), 64'd0);
`ifdef ARB_ROUND_ROBIN_EN
        last_m = w;
`endif
        e_addr = addr_a[w];
        e_wd   = wd_a[w];
        e_we   = we_a[w];
        addr_a[w] = ~addr_a[w];
        wd_a[w]   = ~wd_a[w];
        we_a[w]   = ~we_a[w];
        drive_cmds();
        if (drop) begin
            pend[w] = 1'b0;
            req     = pend;
        end
        for (int s = 0; s < stall; s++) begin
            mem_ready = 1'b0;
            @(negedge clk);
            chk("stall_valid", 64'(mem_valid), 64'd1);
            chk("stall_addr", 64'(mem_addr), 64'(e_addr));
            chk("stall_wdata", 64'(mem_wdata), 64'(e_wd));
            chk("stall_we", 64'(mem_we), 64'(e_we));
            chk("stall_nodone", 64'(done), 64'd0);
        end
        mem_ready = 1'b1;
        mem_rdata = rd;
        @(negedge clk);
        chk("done_pulse", 64'(done), 64'd1 << w);
        chk("done_rdata", 64'(rdata), 64'(rd));
        chk("done_novalid", 64'(mem_valid), 64'd0);
        chk("done_busy", 64'(busy), 64'd1);
        mem_ready = 1'b0;
        mem_rdata = $urandom;
        @(negedge clk);
        chk("idle_nodone", 64'(done), 64'd0);
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_novalid", 64'(mem_valid), 64'd0);
        pend[w] = 1'b0;
        req     = pend;
        $display("txn owner=%0d stall=%0d drop=%0d rdata=%08h pend=%b", w, stall, drop, rd, pend);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        pend      = '0;
        req       = '0;
        mem_ready = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        last_m = NR - 1;
`endif
        @(negedge clk);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_valid"}, 64'(mem_valid), 64'd0);
        chk({tag, "_we"}, 64'(mem_we), 64'd0);
        chk({tag, "_addr"}, 64'(mem_addr), 64'd0);
        chk({tag, "_wdata"}, 64'(mem_wdata), 64'd0);
        chk({tag, "_done"}, 64'(done), 64'd0);
        chk({tag, "_rdata"}, 64'(rdata), 64'd0);
        chk({tag, "_owner"}, 64'(owner), 64'd0);
        chk({tag, "_busy"}, 64'(busy), 64'd0);
    endtask

    int want_rr [5];
    int want_pri [2];
    int want_after_rst;

    initial begin
`ifdef ARB_ROUND_ROBIN_EN
        want_rr        = '{0, 1, 2, 3, 0};
        want_pri       = '{1, 1};
        want_after_rst = 0;
        last_m         = NR - 1;
`else
        want_rr        = '{3, 3, 3, 3, 3};
        want_pri       = '{2, 1};
        want_after_rst = 3;
`endif
        rstn = 1'b0; req = '0; req_we = '0; req_addr = '0; req_wdata = '0;
        mem_ready = 1'b0; mem_rdata = '0; pend = '0;
        for (int i = 0; i < NR; i++) begin
            addr_a[i] = '0; wd_a[i] = '0; we_a[i] = 1'b0;
        end

        @(negedge clk);
        @(negedge clk);
        chk_reset_outputs("rst_held");
        rstn = 1'b1;
        @(negedge clk);
        chk_reset_outputs("rst_released");

        // Single read, zero-wait memory
        raise(4'b0001);
        addr_a[0] = 32'h100;
        we_a[0]   = 1'b0;
        run_txn(0, 1'b0, 0, 32'hDEADBEEF);

        // All four requesting, re-raised after every completion
        do_reset();
        for (int t = 0; t < 5; t++) begin
            raise(4'b1111);
            run_txn(0, 1'b0, want_rr[t], $urandom);
        end

        pend = '0;
        raise(4'b0110);
        run_txn(0, 1'b0, want_pri[0], $urandom);
        pend = '0;
        raise(4'b0010);
        run_txn(0, 1'b0, want_pri[1], $urandom);

        // Memory stall of five cycles, then a requester that drops early
        pend = '0;
        raise(4'b0100);
        run_txn(5, 1'b0, 2, 32'h1234_5678);
        raise(4'b1000);
        run_txn(1, 1'b1, 3, 32'hCAFE_F00D);

        // Reset while a transaction is in flight
        pend = '0;
        raise(4'b0011);
        drive_cmds();
        req       = pend;
        mem_ready = 1'b0;
        @(negedge clk);
        chk("midrst_busy_before", 64'(mem_valid), 64'd1);
        rstn = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        pend = '0;
        req  = '0;
        @(negedge clk);
        chk("midrst_nodone", 64'(done), 64'd0);
        rstn = 1'b1;
`ifdef ARB_ROUND_ROBIN_EN
        last_m = NR - 1;
`endif
        @(negedge clk);
        chk("midrst_idle", 64'(busy), 64'd0);
        raise(4'b1000);
        run_txn(0, 1'b0, 3, $urandom);
        raise(4'b1111);
        run_txn(0, 1'b0, want_after_rst, $urandom);

        // Random traffic
        for (int t = 0; t < 40; t++) begin
            raise(4'($urandom_range(0, 15)));
            if (pend == '0) raise(4'(1 << $urandom_range(0, 3)));
            run_txn(int'($urandom_range(0, 3)), ($urandom_range(0, 3) == 0), -1, $urandom);
        end

        pend = '0;
        req  = '0;
        @(negedge clk);
        chk("final_idle", 64'(busy), 64'd0);
        @(negedge clk);
        chk("final_novalid", 64'(mem_valid), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Shares a single memory port among 2**N requesters (fetch, load/store, debug, DMA) using one-transaction-at-a-time arbitration. Requester selection reduces the request vector to a winner index and a valid flag, then the winner's command is latched and presented to memory with a valid/ready handshake. Completion returns a one-cycle `done` pulse to the owner together with registered read data. The block sits between the core's memory clients and the unified memory/bus interface.

## Interface
- `N`, 2: requester index width; requester count is 2**N.
- `AW`, 32: address width.
- `DW`, 32: data width.

- `clk`  in  1  system clock; all state updates on rising edge.
- `rstn`  in  1  asynchronous, active-low reset.
- `req`  in  2**N  per-requester request; held high until own `done` pulse.
- `req_we`  in  2**N  per-requester write enable.
- `req_addr`  in  2**N*AW  packed addresses; requester i at [i*AW +: AW].
- `req_wdata`  in  2**N*DW  packed write data; requester i at [i*DW +: DW].
- `done`  out  2**N  one-hot one-cycle completion pulse to owner.
- `rdata`  out  DW  read data of completed transaction; valid while `done` != 0.
- `owner`  out  N  index of current/last granted requester.
- `busy`  out  1  high in BUSY and DONE states.
- `mem_valid`  out  1  command valid to memory.
- `mem_ready`  in  1  memory accepts and completes command this cycle.
- `mem_we`, `mem_addr` (AW), `mem_wdata` (DW)  out  latched command of owner.
- `mem_rdata`  in  DW  read data, valid in the cycle `mem_valid && mem_ready`.

## Operation
- States: IDLE, BUSY, DONE. Reset → IDLE.
- IDLE: if `req` != 0, select winner, latch `owner`, `req_we/addr/wdata` of winner into command registers, go BUSY. If `req` == 0, stay IDLE, command registers unchanged.
- BUSY: `mem_valid`=1 with latched command. On `mem_ready`=1: capture `mem_rdata` into `rdata` (writes capture it too, value don't-care to requester), set `done[owner]`=1, go DONE. On `mem_ready`=0: hold everything.
- DONE: `done[owner]`=1 for this single cycle, `mem_valid`=0, no arbitration; next state IDLE. `done` is 0 in all other states.
- Requester drops `req` in the cycle after it sees `done`; if still high in IDLE it is treated as a new request.
- Dropping `req` while BUSY does not abort; transaction completes and `done` still pulses.
- Changes to an owner's `req_addr/wdata/we` after latching have no effect.
- Selection (round-robin mode, see Configuration): pointer `last` = owner of last granted transaction; preference order last+1, last+2, …, wrapping modulo 2**N, ending at last. `last` updated at grant.
- Reset mid-transaction: immediate return to IDLE, `mem_valid` drops asynchronously, no `done` issued; the memory side treats the dropped `mem_valid` as abandonment.

## Timing
- Reset values: state IDLE, `mem_valid`=0, `mem_we`=0, `mem_addr`=0, `mem_wdata`=0, `done`=0, `rdata`=0, `owner`=0, `busy`=0, `last`=2**N-1.
- All outputs registered; no combinational path from `req` or `mem_ready` to any output.
- Grant latency: `req` sampled at edge k → `mem_valid`=1 in cycle k+1.
- Zero-wait memory: `mem_ready` in cycle k+1 → `done` and `rdata` in cycle k+2, IDLE in k+3. Minimum 3 cycles per transaction; each memory wait cycle adds one.
- Simultaneous requests resolved in the single IDLE cycle; losers wait unaltered.

## Configuration
- `ARB_ROUND_ROBIN_EN` defined: rotating priority as in Operation; every continuously requesting client served within 2**N transactions.
- Not defined: fixed priority, highest set index of `req` wins (index 2**N-1 highest); `last` register omitted. Timing and handshake identical.

## Test plan
- Reset, `req`=0001, `req_we`=0, addr 0x100, `mem_ready`=1 immediately, `mem_rdata`=0xDEADBEEF → `mem_valid` cycle 1 with addr 0x100, `done`=0001 and `rdata`=0xDEADBEEF cycle 2.
- Round-robin: `req`=1111 held (re-raised after each done) → grant order 0,1,2,3,0; each `done` one cycle, one-hot.
- Fixed priority (macro undefined): `req`=0110 → owner 2; then `req`=0010 → owner 1.
- Memory stall: `mem_ready` low 5 cycles then high → `mem_valid` high 6 cycles, command stable, `done` one cycle after `mem_ready`; changing `req_addr` during stall not seen on `mem_addr`.
- Requester drops `req` one cycle after grant → transaction completes, `done` still pulses.
- `rstn` low during BUSY → `mem_valid`=0 immediately, all outputs at reset values, no `done`; next `req`=1000 after release granted normally (round-robin: index 0 preferred first when multiple).
